// File: rtl/clock_monitor_if.sv
// ============================================================================
// Module   : clock_monitor_if
// Purpose  : Monitored signal in, edge strobes and measurements out.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface clock_monitor_if #(
  parameter int CNT_W = 28
);
  logic             sig_in;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             lost;

  modport master (
    output sig_in,
    input  rise_pulse,
    input  fall_pulse,
    input  period,
    input  high_time,
    input  period_valid,
    input  lost
  );

  modport slave (
    input  sig_in,
    output rise_pulse,
    output fall_pulse,
    output period,
    output high_time,
    output period_valid,
    output lost
  );
endinterface

`default_nettype wire

// File: rtl/clock_monitor.sv
// ============================================================================
// Module   : clock_monitor
// Purpose  : Synchronizes a slow clock, strobes its edges, measures period and
//            high time in clk_in cycles, flags loss on timeout.
//            Optional duty measurement: define CLKMON_DUTY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clock_monitor #(
  parameter int CNT_W   = 28,
  parameter int TIMEOUT = 100000
) (
  input  wire logic        clk_in,
  input  wire logic        rst,
  clock_monitor_if.slave   mon
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOST    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             rise_pulse_q, rise_pulse_d;
  logic             period_valid_q, period_valid_d;
  logic             lost_q, lost_d;
  logic             rise_ev;
  logic             timeout_ev;

  // Two-flop synchronizer plus one history stage for edge detection.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= mon.sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_ev    = s2_q & ~s3_q;
  assign timeout_ev = (cnt_q == TO_LAST) & ~rise_ev;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      rise_pulse_q   <= 1'b0;
      period_valid_q <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      rise_pulse_q   <= rise_pulse_d;
      period_valid_q <= period_valid_d;
      lost_q         <= lost_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    lost_d         = lost_q;
    rise_pulse_d   = rise_ev;

    if (rise_ev) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    // A rise in the timeout cycle takes precedence, so lost never asserts then.
    case (state_q)
      ST_IDLE: begin
        if (rise_ev) begin
          state_d = ST_MEASURE;
        end else if (timeout_ev) begin
          state_d        = ST_LOST;
          lost_d         = 1'b1;
          period_valid_d = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (rise_ev) begin
          period_d       = cnt_q + CNT_ONE;
          period_valid_d = 1'b1;
        end else if (timeout_ev) begin
          state_d        = ST_LOST;
          lost_d         = 1'b1;
          period_valid_d = 1'b0;
        end
      end
      ST_LOST: begin
        if (rise_ev) begin
          state_d = ST_MEASURE;
          lost_d  = 1'b0;
        end else if (timeout_ev) begin
          lost_d         = 1'b1;
          period_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mon.rise_pulse   = rise_pulse_q;
  assign mon.period       = period_q;
  assign mon.period_valid = period_valid_q;
  assign mon.lost         = lost_q;

`ifdef CLKMON_DUTY_EN
  logic             fall_ev;
  logic             fall_pulse_q, fall_pulse_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;

  assign fall_ev = ~s2_q & s3_q;

  always_comb begin
    fall_pulse_d = fall_ev;
    high_time_d  = high_time_q;
    if (fall_ev && (state_q == ST_MEASURE)) begin
      high_time_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      fall_pulse_q <= 1'b0;
      high_time_q  <= '0;
    end else begin
      fall_pulse_q <= fall_pulse_d;
      high_time_q  <= high_time_d;
    end
  end

  assign mon.fall_pulse = fall_pulse_q;
  assign mon.high_time  = high_time_q;
`else
  assign mon.fall_pulse = 1'b0;
  assign mon.high_time  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clock_monitor.sv
// Scoreboard bench for clock_monitor: edge-indexed reference model feeds a
// queue of expected outputs, a monitor pops and compares every cycle.
`default_nettype none

module tb_clock_monitor;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 20;

  typedef struct packed {
    logic             rp;
    logic             fp;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] ht;
    logic             pv;
    logic             lost;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  clock_monitor_if #(.CNT_W(CNT_W)) ifc ();

  clock_monitor #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .mon   (ifc)
  );

  always #5 clk_in = ~clk_in;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: edges are numbered; a rise is registered at edge n when
  // the input sampled at edge n-2 was high and at edge n-3 was low (samples
  // at or before the last reset edge count as low).
  int   n        = 0;
  int   rst_edge = -1;
  bit   samp[int];
  bit   m_seen, m_lost, m_pv;
  int   m_last_rise;
  int   m_period, m_high;

  function automatic bit smp(int k);
    if (k <= rst_edge) return 1'b0;
    return samp.exists(k) ? samp[k] : 1'b0;
  endfunction

  task automatic model_step(input bit s, input bit r);
    exp_t e;
    bit   rise, fall;
    n++;
    e = '0;
    if (r) begin
      rst_edge    = n;
      m_seen      = 0;
      m_lost      = 0;
      m_pv        = 0;
      m_last_rise = n;
      m_period    = 0;
      m_high      = 0;
    end else begin
      samp[n] = s;
      rise = smp(n - 2) && !smp(n - 3);
      fall = !smp(n - 2) && smp(n - 3);
      if (fall && m_seen && !m_lost) m_high = n - m_last_rise;
      if (rise) begin
        if (m_seen && !m_lost) begin
          m_period = n - m_last_rise;
          m_pv     = 1;
        end
        m_seen      = 1;
        m_lost      = 0;
        m_last_rise = n;
      end else if (n - m_last_rise == TIMEOUT) begin
        m_lost = 1;
        m_pv   = 0;
      end
      e.rp = rise;
`ifdef CLKMON_DUTY_EN
      e.fp = fall;
`endif
    end
    e.per  = CNT_W'(m_period);
`ifdef CLKMON_DUTY_EN
    e.ht   = CNT_W'(m_high);
`endif
    e.pv   = m_pv;
    e.lost = m_lost;
    sbq.push_back(e);
  endtask

  task automatic cyc(input bit s, input bit r);
    @(negedge clk_in);
    ifc.sig_in = s;
    rst        = r;
    model_step(s, r);
  endtask

  task automatic wave(input int per, input int hi, input int reps);
    for (int k = 0; k < reps; k++)
      for (int i = 0; i < per; i++) cyc(i < hi, 1'b0);
  endtask

  task automatic hold(input bit s, input int len);
    for (int i = 0; i < len; i++) cyc(s, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rise_pulse",   32'(ifc.rise_pulse),   32'(e.rp));
        chk("fall_pulse",   32'(ifc.fall_pulse),   32'(e.fp));
        chk("period",       32'(ifc.period),       32'(e.per));
        chk("high_time",    32'(ifc.high_time),    32'(e.ht));
        chk("period_valid", 32'(ifc.period_valid), 32'(e.pv));
        chk("lost",         32'(ifc.lost),         32'(e.lost));
      end
    end
  end

  initial begin : stimulus
    int per, hi, sel;
    ifc.sig_in = 1'b0;
    repeat (3) cyc(1'b0, 1'b1);
    wave(10, 4, 4);
    hold(1'b0, 40);
    wave(6, 3, 4);
    wave(20, 10, 3);
    wave(10, 4, 2);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    hold(1'b1, 3);
    wave(10, 4, 3);
    hold(1'b0, 25);
    for (int it = 0; it < 250; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        hold(1'b0, int'($urandom_range(15, 30)));
      end else if (sel == 1) begin
        repeat (int'($urandom_range(1, 2))) cyc(1'($urandom), 1'b1);
      end else begin
        per = int'($urandom_range(2, 30));
        hi  = int'($urandom_range(1, per - 1));
        wave(per, hi, int'($urandom_range(1, 4)));
      end
    end
    hold(1'b0, 5);
    repeat (2) @(posedge clk_in);
    #2;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
